// File: rtl/apb_gpio_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_master
// Purpose  : valid/ready command port to APB master bridge with a PREADY timeout.
//            Optional PSLVERR input enabled by APB_GPIO_MASTER_PSLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
`ifdef APB_GPIO_MASTER_PSLVERR_EN
    input  logic                PSLVERR,
`endif
    input  logic                PREADY
);

    localparam int                 c_CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_cnt_inc;
    logic               w_accept;
    logic               w_done;
    logic               w_abort;
    logic               w_slverr;

`ifdef APB_GPIO_MASTER_PSLVERR_EN
    assign w_slverr = PSLVERR;
`else
    assign w_slverr = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_done         = 1'b0;
        w_abort        = 1'b0;
        w_wait_cnt_inc = r_wait_cnt + c_CNT_ONE;
        req_ready      = (r_state == S_IDLE) && !PRESET;
        PSEL           = 1'b0;
        PENABLE        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && (r_state == S_IDLE) && !PRESET) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                PSEL        = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // PREADY wins over a timeout landing in the same cycle
                if (PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (c_TIMEOUT_EN && (w_wait_cnt_inc == c_TIMEOUT)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET || (r_state == S_SETUP)) begin
            r_wait_cnt <= '0;
        end else if (c_TIMEOUT_EN && (r_state == S_ACCESS) && !PREADY) begin
            r_wait_cnt <= w_wait_cnt_inc;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_done || w_abort;
            if (w_accept) begin
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PWDATA <= req_wdata;
                PSTRB  <= req_write ? req_strb : '0;
            end
            if (w_done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= w_slverr;
            end else if (w_abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_master
// Purpose  : Self-checking bench for apb_gpio_master with a cycle-timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          PCLK      = 1'b0;
    logic          PRESET    = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb  = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA    = '0;
    logic          PREADY    = 1'b0;
`ifdef APB_GPIO_MASTER_PSLVERR_EN
    logic          PSLVERR   = 1'b0;
`endif

    apb_gpio_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
`ifdef APB_GPIO_MASTER_PSLVERR_EN
        .PSLVERR   (PSLVERR),
`endif
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Transaction timeline: accepted in cycle t_acc, SETUP at t_acc+1,
    // ACCESS for m_len cycles, response in the cycle after the last ACCESS.
    int            cyc     = 0;
    int            t_acc   = -1000;
    int            m_len   = 0;
    int            m_waits = 0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_prd   = '0;
    logic [SW-1:0] m_strb  = '0;
    bit            m_slv   = 1'b0;

    int            s_waits = 0;
    logic [DW-1:0] s_prd   = '0;
    bit            s_slv   = 1'b0;

    int            n_acc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            dut_rsp_n = 0;
    int            last_rsp_cyc = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    function automatic bit f_psel(input int c);
        return (c >= t_acc + 1) && (c <= t_acc + 1 + m_len);
    endfunction

    function automatic bit f_pen(input int c);
        return (c >= t_acc + 2) && (c <= t_acc + 1 + m_len);
    endfunction

    function automatic bit f_rspv(input int c);
        return c == t_acc + 2 + m_len;
    endfunction

    function automatic bit f_err();
        return (m_waits >= TO) || m_slv;
    endfunction

    function automatic logic [DW-1:0] f_rdata();
        return ((m_waits >= TO) || m_write) ? '0 : m_prd;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge PCLK) begin
        if (PRESET) begin
            t_acc   = -1000;
            m_len   = 0;
            m_waits = 0;
            m_write = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_strb  = '0;
            m_slv   = 1'b0;
        end else if (req_valid && !f_psel(cyc)) begin
            t_acc   = cyc;
            m_write = req_write;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_strb  = req_write ? req_strb : '0;
            m_waits = s_waits;
            m_len   = (s_waits < TO) ? s_waits + 1 : TO;
            m_prd   = s_prd;
            m_slv   = s_slv;
            n_acc++;
        end
        cyc++;
    end

    // Slave: completes after m_waits wait states; noise on the bus otherwise.
    always @(posedge PCLK) begin
        #1;
        if (f_pen(cyc)) begin
            PREADY = (cyc == t_acc + 2 + m_waits);
            PRDATA = m_prd;
`ifdef APB_GPIO_MASTER_PSLVERR_EN
            PSLVERR = m_slv;
`endif
        end else begin
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
`ifdef APB_GPIO_MASTER_PSLVERR_EN
            PSLVERR = 1'($urandom_range(0, 1));
`endif
        end
    end

    always @(negedge PCLK) begin
        if (cyc >= 1) begin
            chk("req_ready", req_ready, !PRESET && !f_psel(cyc));
            chk("psel", PSEL, f_psel(cyc));
            chk("penable", PENABLE, f_pen(cyc));
            chk("rsp_valid", rsp_valid, f_rspv(cyc));
            chk("apb_bus", {PADDR, PWRITE, PWDATA, PSTRB}, {m_addr, m_write, m_wdata, m_strb});
            if (f_rspv(cyc)) begin
                chk("rsp_rdata", rsp_rdata, f_rdata());
                chk("rsp_err", rsp_err, f_err());
            end
        end
        if (rsp_valid === 1'b1) begin
            dut_rsp_n++;
            last_rsp_cyc = cyc;
            last_rdata   = rsp_rdata;
            last_err     = rsp_err;
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int waits, input logic [DW-1:0] prd,
                        input bit slv);
        int n0;
        n0        = n_acc;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        s_waits   = waits;
        s_prd     = prd;
        s_slv     = slv;
        for (int i = 0; i < 60 && n_acc == n0; i++) tick();
        chk("accept_seen", n_acc != n0, 1'b1);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = SW'($urandom);
    endtask

    task automatic wait_rsp(input int n0);
        for (int i = 0; i < 40 && dut_rsp_n == n0; i++) tick();
        chk("rsp_seen", dut_rsp_n != n0, 1'b1);
    endtask

    initial begin
        int a;
        int a2;
        int n0;
        // Reset held for two sampled edges
        tick();
        chk("rst_ready_low", req_ready, 1'b0);
        tick();
        PRESET = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_bus", {PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA}, '0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);

        n0 = dut_rsp_n;
        send(1'b1, 32'h0000_0000, 32'hAF78_CF55, 4'b0001, 0, 32'h0, 1'b0);
        a = t_acc;
        wait_rsp(n0);
        chk("wr_latency", last_rsp_cyc - a, 3);
        chk("wr_err", last_err, 1'b0);
        chk("wr_rdata", last_rdata, 32'h0);
        chk("wr_pstrb", PSTRB, 4'b0001);

        n0 = dut_rsp_n;
        send(1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 2, 32'h0000_000A, 1'b0);
        a = t_acc;
        wait_rsp(n0);
        chk("rd_latency", last_rsp_cyc - a, 5);
        chk("rd_rdata", last_rdata, 32'h0000_000A);
        chk("rd_err", last_err, 1'b0);
        chk("rd_pstrb", PSTRB, 4'b0000);

        n0 = dut_rsp_n;
        send(1'b1, 32'h0000_0010, 32'hCCAA_FF44, 4'b0001, 0, 32'h0, 1'b0);
        a = t_acc;
        send(1'b1, 32'h0000_0014, 32'hCCAA_85FF, 4'b0010, 0, 32'h0, 1'b0);
        a2 = t_acc;
        chk("b2b_accept", a2 - a, 3);
        repeat (8) tick();
        chk("b2b_rsp_count", dut_rsp_n - n0, 2);

        n0 = dut_rsp_n;
        send(1'b0, 32'h0000_0040, 32'h0, 4'hF, 100, 32'h1234_5678, 1'b0);
        a = t_acc;
        wait_rsp(n0);
        chk("to_latency", last_rsp_cyc - a, 6);
        chk("to_err", last_err, 1'b1);
        chk("to_rdata", last_rdata, 32'h0);

        send(1'b0, 32'h0000_0044, 32'h0, 4'hF, 3, 32'h0000_BEEF, 1'b0);
        a = t_acc;
        while (cyc < a + 3) tick();
        n0     = dut_rsp_n;
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("midrst_psel", {PSEL, PENABLE}, 2'b00);
        repeat (8) tick();
        chk("midrst_no_rsp", dut_rsp_n - n0, 0);

`ifdef APB_GPIO_MASTER_PSLVERR_EN
        n0 = dut_rsp_n;
        send(1'b0, 32'h0000_0048, 32'h0, 4'hF, 1, 32'h0000_5A5A, 1'b1);
        wait_rsp(n0);
        chk("slverr_err", last_err, 1'b1);
        chk("slverr_rdata", last_rdata, 32'h0000_5A5A);
`endif

        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 49) == 0) begin
                PRESET = 1'b1;
                tick();
                PRESET = 1'b0;
            end
`ifdef APB_GPIO_MASTER_PSLVERR_EN
            send(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom),
                 $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
`else
            send(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom),
                 $urandom_range(0, 5), $urandom, 1'b0);
`endif
        end
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
